mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Upstream traffic stage for memory_hierarchy; takes the processor slot in top.
//  Issues a write pass, then a read pass, over NUM_ACCESSES word addresses.
//  Read-pass addresses repeat the write-pass addresses in the same order.
//  Address pattern is selectable. Counts accepted accesses and read hits.
//  Optional: checks read data against the written pattern.
// PARAMETERS
//  ADDR_W        16        request address width (byte address)
//  DATA_W        32        write/read data width
//  NUM_ACCESSES  256       accesses per pass (>=1)
//  STRIDE        4         word stride for mode 1 (byte step = STRIDE*4)
//  LFSR_SEED     16'hACE1  non-zero seed for mode 2
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low (0 = reset)
//  start         in   1       one-cycle pulse; starts a run when idle
//  mode          in   2       0 sequential, 1 strided, 2 LFSR, 3 treated as 0
//  req_ready     in   1       memory_hierarchy accepts the request this cycle
//  read_data     in   DATA_W  read data from memory_hierarchy
//  hit           in   1       hit flag from memory_hierarchy
//  read_en       out  1       read request
//  write_en      out  1       write request
//  address       out  ADDR_W  request address, word aligned ([1:0]=0)
//  write_data    out  DATA_W  write payload
//  busy          out  1       run in progress
//  done          out  1       run complete; held until the next accepted start
//  access_count  out  32      accepted requests (both passes)
//  hit_count     out  32      read-pass accepts with hit=1
//  mismatch_cnt  out  16      read-data mismatches (see CONFIGURATION)
// BEHAVIOUR
//  Reset value of every output is 0, applied asynchronously; FSM returns to IDLE.
//  Reset mid-run abandons the run with no residue; the next start begins fresh.
//  FSM states and transitions:
//   IDLE  -> WRITE on start.
//   WRITE -> READ after NUM_ACCESSES accepts.
//   READ  -> DONE after NUM_ACCESSES accepts.
//   DONE  -> WRITE on start.
//  mode is latched on the start pulse; changes to mode during a run are ignored.
//  A start pulse while busy is ignored.
//  Request presentation:
//   WRITE drives write_en=1; READ drives read_en=1.
//   The two enables are never high together.
//  Acceptance:
//   A request is accepted when its enable and req_ready are both 1.
//   address and write_data stay stable until the request is accepted.
//   On acceptance the pass counter increments and the next address is
//   presented in the following cycle, giving 1 request/cycle at full ready.
//  Read response: hit and read_data are sampled in the acceptance cycle (zero latency).
//  Address generation, i = pass index, 0..NUM_ACCESSES-1:
//   mode 0: addr = i*4
//   mode 1: addr = i*STRIDE*4
//   mode 2: addr = {lfsr[ADDR_W-1:2],2'b00}
//   All sums wrap modulo 2^ADDR_W.
//  LFSR (mode 2):
//   16-bit Fibonacci, taps 16,14,13,11.
//   Reloaded with LFSR_SEED at the start of each pass.
//   Advances once per accept.
//  Write pattern: pat(a) = {a, ~a} truncated/zero-extended to DATA_W.
//  Timing of state changes:
//   busy=1 from the cycle after start until the cycle DONE is entered.
//   done rises in that same cycle.
//   start from DONE clears done and raises busy together.
//  Counters:
//   All are cleared on an accepted start.
//   access_count and hit_count saturate at all-ones; mismatch_cnt saturates at 16'hFFFF.
//  Boundary case NUM_ACCESSES=1: each pass issues exactly one request.
// CONFIGURATION
//  Macro: SEQ_READBACK_CHECK_EN.
//  Defined:
//   On each read accept, compare read_data to pat(address).
//   Increment mismatch_cnt on inequality.
//  Undefined:
//   No compare logic; mismatch_cnt is tied to 0.
//   The port remains present so the top-level connection is unchanged.
// STRUCTURE
//  Package mem_seq_pkg holds:
//   enum seq_state_e {IDLE,WRITE,READ,DONE}
//   enum seq_mode_e  {SEQ,STRIDED,LFSR}
//   function pat() and the LFSR tap constant.
//  Sub-module seq_addr_gen:
//   Holds the index counter, the LFSR and the mode mux.
//   Ports: clk, reset, restart, advance, mode -> address.
// TESTING
//  T1 mode 0, NUM_ACCESSES=4, req_ready=1:
//     writes at 0,4,8,C with data 0000_FFFF, 0004_FFFB, ...; then reads at the same addresses;
//     done after 8 accepts; access_count=8.
//  T2 mode 1, STRIDE=4, req_ready toggling 1,0:
//     addresses 0,0x10,0x20,0x30 each held through the stall; no skipped or duplicated requests.
//  T3 mode 2: read-pass address sequence equals write-pass sequence;
//     first address = {ACE1[15:2],2'b00} = 0xACE0.
//  T4 mode 1, STRIDE=0x4000, NUM_ACCESSES=5:
//     addresses 0,0,0,0,0 (wrap); hit_count matches the model.
//  T5 reset low mid-WRITE:
//     all outputs 0 at once; new start gives a clean run with counts from 0.
//  T6 SEQ_READBACK_CHECK_EN defined, one read_data bit corrupted on the 2nd read:
//     mismatch_cnt=1. Macro undefined: mismatch_cnt=0.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory access sequencer.
// Holds the FSM and mode encodings, the LFSR tap mask and the write-pattern function.
package mem_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      SEQ     = 2'd0,
      STRIDED = 2'd1,
      LFSR    = 2'd2
   } seq_mode_e;

   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   // Write pattern {a, ~a} built over aw address bits; callers cut it to the data width.
   function automatic logic [63:0] pat(input logic [31:0] a, input int unsigned aw);
      logic [63:0] mask;
      logic [63:0] av;
      mask = (64'd1 << aw) - 64'd1;
      av   = {32'd0, a} & mask;
      pat  = (av << aw) | (~av & mask);
   endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Address generator for the memory access sequencer.
// Keeps the pass index and LFSR, and registers the address for the selected mode.
// restart reloads index 0 / LFSR seed; advance steps to the next pass index.
module seq_addr_gen
   import mem_seq_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter int          STRIDE    = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              advance,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] address
);

   localparam logic [ADDR_W-1:0] STRIDE_W   = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] ADDR_ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_lfsr;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic [15:0]       w_lfsr_nxt;
   logic [ADDR_W-1:0] w_mul;
   logic [ADDR_W-1:0] w_lfsr_ext;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_fb;

   assign w_fb       = ^(r_lfsr & LFSR_TAP_MASK);
   assign w_mul      = w_idx_nxt * STRIDE_W;
   assign w_lfsr_ext = ADDR_W'(w_lfsr_nxt);
   assign address    = r_addr;

   // Next index / LFSR value: reload on restart, step on advance, otherwise hold.
   always_comb begin
      w_idx_nxt  = r_idx;
      w_lfsr_nxt = r_lfsr;
      if (restart) begin
         w_idx_nxt  = {ADDR_W{1'b0}};
         w_lfsr_nxt = LFSR_SEED;
      end else if (advance) begin
         w_idx_nxt  = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
         w_lfsr_nxt = {w_fb, r_lfsr[15:1]};
      end else begin
         w_idx_nxt  = r_idx;
         w_lfsr_nxt = r_lfsr;
      end
   end

   // Mode mux; products and shifts wrap naturally at ADDR_W bits, mode 3 behaves as mode 0.
   always_comb begin
      w_addr_nxt = w_idx_nxt << 2'd2;
      case (mode)
         SEQ:     w_addr_nxt = w_idx_nxt << 2'd2;
         STRIDED: w_addr_nxt = w_mul << 2'd2;
         LFSR:    w_addr_nxt = w_lfsr_ext & ADDR_ALIGN;
         default: w_addr_nxt = w_idx_nxt << 2'd2;
      endcase
   end

   // Index, LFSR and registered address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx  <= {ADDR_W{1'b0}};
         r_lfsr <= LFSR_SEED;
         r_addr <= {ADDR_W{1'b0}};
      end else begin
         r_idx  <= w_idx_nxt;
         r_lfsr <= w_lfsr_nxt;
         r_addr <= w_addr_nxt;
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: a write pass then a read pass over NUM_ACCESSES addresses,
// counting accepted requests and read hits.
// Optional macro SEQ_READBACK_CHECK_EN adds read-data checking against the write pattern;
// without it mismatch_cnt is tied to zero.
module mem_access_sequencer
   import mem_seq_pkg::*;
#(
   parameter int          ADDR_W       = 16,
   parameter int          DATA_W       = 32,
   parameter int          NUM_ACCESSES = 256,
   parameter int          STRIDE       = 4,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              req_ready,
   input  logic [DATA_W-1:0] read_data,
   input  logic              hit,
   output logic              read_en,
   output logic              write_en,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       access_count,
   output logic [31:0]       hit_count,
   output logic [15:0]       mismatch_cnt
);

   seq_state_e        r_state;
   seq_state_e        w_state_nxt;
   logic [1:0]        r_mode;
   logic [1:0]        w_mode_sel;
   logic [31:0]       r_pass_cnt;
   logic [31:0]       r_access_cnt;
   logic [31:0]       r_hit_cnt;
   logic              r_write_en;
   logic              r_read_en;
   logic              r_busy;
   logic              r_done;
   logic              w_start_acc;
   logic              w_accept;
   logic              w_last;
   logic              w_restart;
   logic              w_advance;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_pat;

   assign w_start_acc = start & ((r_state == IDLE) | (r_state == DONE));
   assign w_accept    = (r_write_en | r_read_en) & req_ready;
   assign w_last      = (r_pass_cnt == 32'(NUM_ACCESSES - 1));
   // The generator must see the new mode in the start cycle itself.
   assign w_mode_sel  = w_start_acc ? mode : r_mode;
   assign w_pat       = DATA_W'(pat(32'(w_addr), ADDR_W));

   seq_addr_gen #(
      .ADDR_W    (ADDR_W),
      .STRIDE    (STRIDE),
      .LFSR_SEED (LFSR_SEED)
   ) u_addr_gen (
      .clk     (clk),
      .reset   (reset),
      .restart (w_restart),
      .advance (w_advance),
      .mode    (w_mode_sel),
      .address (w_addr)
   );

   // Next state plus generator control: restart at each pass start, advance on other accepts.
   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = WRITE;
               w_restart   = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         WRITE: begin
            if (w_accept) begin
               if (w_last) begin
                  w_state_nxt = READ;
                  w_restart   = 1'b1;
               end else begin
                  w_advance   = 1'b1;
               end
            end else begin
               w_state_nxt = WRITE;
            end
         end
         READ: begin
            if (w_accept) begin
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_advance   = 1'b1;
               end
            end else begin
               w_state_nxt = READ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register and state-decoded output flags, all updated from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_write_en <= 1'b0;
         r_read_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_write_en <= (w_state_nxt == WRITE);
         r_read_en  <= (w_state_nxt == READ);
         r_busy     <= (w_state_nxt == WRITE) | (w_state_nxt == READ);
         r_done     <= (w_state_nxt == DONE);
      end
   end

   // Mode latch and per-pass accept counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode     <= 2'd0;
         r_pass_cnt <= 32'd0;
      end else if (w_start_acc) begin
         r_mode     <= mode;
         r_pass_cnt <= 32'd0;
      end else if (w_accept) begin
         r_pass_cnt <= w_last ? 32'd0 : r_pass_cnt + 32'd1;
      end else begin
         r_pass_cnt <= r_pass_cnt;
      end
   end

   // Saturating access and read-hit counters, cleared on an accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_access_cnt <= 32'd0;
         r_hit_cnt    <= 32'd0;
      end else if (w_start_acc) begin
         r_access_cnt <= 32'd0;
         r_hit_cnt    <= 32'd0;
      end else begin
         if (w_accept && (r_access_cnt != 32'hFFFF_FFFF)) begin
            r_access_cnt <= r_access_cnt + 32'd1;
         end
         if (r_read_en && req_ready && hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
      end
   end

`ifdef SEQ_READBACK_CHECK_EN
   logic [15:0] r_mismatch_cnt;

   // Saturating count of read accepts whose data differs from the written pattern.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mismatch_cnt <= 16'd0;
      end else if (w_start_acc) begin
         r_mismatch_cnt <= 16'd0;
      end else if (r_read_en && req_ready && (read_data != w_pat) && (r_mismatch_cnt != 16'hFFFF)) begin
         r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
      end else begin
         r_mismatch_cnt <= r_mismatch_cnt;
      end
   end

   assign mismatch_cnt = r_mismatch_cnt;
`else
   logic w_unused_rd;

   assign w_unused_rd  = ^read_data;
   assign mismatch_cnt = 16'd0;
`endif

   assign write_en     = r_write_en;
   assign read_en      = r_read_en;
   assign address      = w_addr;
   assign write_data   = r_write_en ? w_pat : {DATA_W{1'b0}};
   assign busy         = r_busy;
   assign done         = r_done;
   assign access_count = r_access_cnt;
   assign hit_count    = r_hit_cnt;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed testbench for mem_access_sequencer (one instance with 4 accesses per pass,
// one with 5 accesses and a wrapping stride).
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, req_ready, hit;
   logic [1:0]  mode;
   logic [31:0] read_data;
   logic        read_en, write_en, busy, done;
   logic [15:0] address;
   logic [31:0] write_data, access_count, hit_count;
   logic [15:0] mismatch_cnt;

   logic        start_b, ready_b, hit_b;
   logic [1:0]  mode_b;
   logic [31:0] read_data_b;
   logic        read_en_b, write_en_b, busy_b, done_b;
   logic [15:0] address_b;
   logic [31:0] write_data_b, access_count_b, hit_count_b;
   logic [15:0] mismatch_cnt_b;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] cap_addr [0:15];
   logic [31:0] cap_data [0:15];
   bit          cap_wr   [0:15];
   int          n_cap, stall_viol, cyc, rd_num;
   bit          corrupt_en, timed_out, busy_after, done_after;

   always #5 clk = ~clk;

   function automatic logic [31:0] tb_pat(input logic [15:0] a);
      return {a, ~a};
   endfunction

   assign hit         = address[2];
   assign read_data   = tb_pat(address) ^ ((corrupt_en && read_en && rd_num == 1) ? 32'h0000_0100 : 32'h0);
   assign hit_b       = 1'b1;
   assign read_data_b = 32'h0000_FFFF;

   mem_access_sequencer #(.NUM_ACCESSES(4), .STRIDE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .req_ready(req_ready),
      .read_data(read_data), .hit(hit), .read_en(read_en), .write_en(write_en),
      .address(address), .write_data(write_data), .busy(busy), .done(done),
      .access_count(access_count), .hit_count(hit_count), .mismatch_cnt(mismatch_cnt)
   );

   mem_access_sequencer #(.NUM_ACCESSES(5), .STRIDE(16'h4000)) dut_wrap (
      .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .req_ready(ready_b),
      .read_data(read_data_b), .hit(hit_b), .read_en(read_en_b), .write_en(write_en_b),
      .address(address_b), .write_data(write_data_b), .busy(busy_b), .done(done_b),
      .access_count(access_count_b), .hit_count(hit_count_b), .mismatch_cnt(mismatch_cnt_b)
   );

   // Start a run on dut and record every accepted request until done (bounded).
   task automatic run_capture(input logic [1:0] m, input bit toggle);
      bit          ph, prev_stall, was_rd;
      logic [15:0] p_addr;
      logic [31:0] p_data;
      n_cap = 0; stall_viol = 0; cyc = 0; rd_num = 0; ph = 1'b0; prev_stall = 1'b0;
      mode = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode = m ^ 2'b01;
      busy_after = busy; done_after = done;
      while (!done && cyc < 200) begin
         start = (cyc == 3);
         req_ready = toggle ? ~ph : 1'b1;
         ph = ~ph;
         @(negedge clk);
         if (prev_stall && (address !== p_addr || write_data !== p_data || !(write_en | read_en)))
            stall_viol++;
         was_rd = 1'b0;
         if ((write_en | read_en) && req_ready) begin
            if (n_cap < 16) begin
               cap_addr[n_cap] = address; cap_data[n_cap] = write_data; cap_wr[n_cap] = write_en;
            end
            n_cap++;
            was_rd = read_en;
         end
         prev_stall = (write_en | read_en) && !req_ready;
         p_addr = address; p_data = write_data;
         @(posedge clk); #1;
         cyc++;
         if (was_rd) rd_num++;
      end
      start = 1'b0;
      timed_out = !done;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mode = 2'd0; req_ready = 1'b0; corrupt_en = 1'b0;
      start_b = 1'b0; mode_b = 2'd0; ready_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({write_en, read_en, busy, done} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b expected 0000", {write_en, read_en, busy, done}); end
      n_cmp++; if (address !== 16'h0 || write_data !== 32'h0) begin n_err++; $display("FAIL rst_addr_data: got %h/%h expected 0/0", address, write_data); end
      n_cmp++; if (access_count !== 32'h0 || hit_count !== 32'h0 || mismatch_cnt !== 16'h0) begin n_err++; $display("FAIL rst_counts: got %h/%h/%h expected 0", access_count, hit_count, mismatch_cnt); end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sequential();
      run_capture(2'd0, 1'b0);
      n_cmp++; if (timed_out || n_cap !== 8) begin n_err++; $display("FAIL t1_accepts: got %0d (timeout %0d) expected 8", n_cap, timed_out); end
      n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL t1_cycles: got %0d expected 8", cyc); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (cap_addr[i] !== 16'(i * 4) || cap_wr[i] !== 1'b1) begin n_err++; $display("FAIL t1_wr_addr[%0d]: got %h wr=%0d expected %h wr=1", i, cap_addr[i], cap_wr[i], 16'(i * 4)); end
         n_cmp++; if (cap_data[i] !== tb_pat(16'(i * 4))) begin n_err++; $display("FAIL t1_wr_data[%0d]: got %h expected %h", i, cap_data[i], tb_pat(16'(i * 4))); end
         n_cmp++; if (cap_addr[i + 4] !== 16'(i * 4) || cap_wr[i + 4] !== 1'b0) begin n_err++; $display("FAIL t1_rd_addr[%0d]: got %h wr=%0d expected %h wr=0", i, cap_addr[i + 4], cap_wr[i + 4], 16'(i * 4)); end
      end
      n_cmp++; if (cap_data[1] !== 32'h0004_FFFB) begin n_err++; $display("FAIL t1_data1: got %h expected 0004fffb", cap_data[1]); end
      n_cmp++; if (access_count !== 32'd8 || hit_count !== 32'd2) begin n_err++; $display("FAIL t1_counts: got %0d/%0d expected 8/2", access_count, hit_count); end
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || busy_after !== 1'b1) begin n_err++; $display("FAIL t1_flags: got done=%b busy=%b busy_after_start=%b expected 1/0/1", done, busy, busy_after); end
      n_cmp++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL t1_mismatch: got %0d expected 0", mismatch_cnt); end
   endtask

   task automatic test_strided_stall();
      run_capture(2'd1, 1'b1);
      n_cmp++; if (busy_after !== 1'b1 || done_after !== 1'b0) begin n_err++; $display("FAIL t2_restart_flags: got busy=%b done=%b expected 1/0", busy_after, done_after); end
      n_cmp++; if (timed_out || n_cap !== 8) begin n_err++; $display("FAIL t2_accepts: got %0d expected 8", n_cap); end
      n_cmp++; if (cyc !== 15) begin n_err++; $display("FAIL t2_cycles: got %0d expected 15", cyc); end
      n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL t2_stall_hold: got %0d violations expected 0", stall_viol); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (cap_addr[i] !== 16'((i % 4) * 16)) begin n_err++; $display("FAIL t2_addr[%0d]: got %h expected %h", i, cap_addr[i], 16'((i % 4) * 16)); end
      end
      n_cmp++; if (access_count !== 32'd8 || hit_count !== 32'd0) begin n_err++; $display("FAIL t2_counts: got %0d/%0d expected 8/0", access_count, hit_count); end
   endtask

   task automatic test_lfsr();
      logic [15:0] exp_a [0:3];
      exp_a[0] = 16'hACE0; exp_a[1] = 16'h5670; exp_a[2] = 16'hAB38; exp_a[3] = 16'h559C;
      run_capture(2'd2, 1'b0);
      n_cmp++; if (timed_out || n_cap !== 8) begin n_err++; $display("FAIL t3_accepts: got %0d expected 8", n_cap); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (cap_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL t3_wr_addr[%0d]: got %h expected %h", i, cap_addr[i], exp_a[i]); end
         n_cmp++; if (cap_addr[i + 4] !== exp_a[i]) begin n_err++; $display("FAIL t3_rd_addr[%0d]: got %h expected %h", i, cap_addr[i + 4], exp_a[i]); end
      end
      n_cmp++; if (cap_data[0] !== 32'hACE0_531F) begin n_err++; $display("FAIL t3_data0: got %h expected ace0531f", cap_data[0]); end
      n_cmp++; if (hit_count !== 32'd1) begin n_err++; $display("FAIL t3_hits: got %0d expected 1", hit_count); end
   endtask

   task automatic test_wrap();
      int n, nz, c;
      n = 0; nz = 0; c = 0;
      mode_b = 2'd1; ready_b = 1'b1; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      while (!done_b && c < 100) begin
         @(negedge clk);
         if (write_en_b | read_en_b) begin
            n++;
            if (address_b !== 16'h0) nz++;
         end
         @(posedge clk); #1;
         c++;
      end
      n_cmp++; if (!done_b || n !== 10) begin n_err++; $display("FAIL t4_accepts: got %0d done=%b expected 10/1", n, done_b); end
      n_cmp++; if (nz !== 0) begin n_err++; $display("FAIL t4_wrap_addr: got %0d nonzero expected 0", nz); end
      n_cmp++; if (access_count_b !== 32'd10 || hit_count_b !== 32'd5) begin n_err++; $display("FAIL t4_counts: got %0d/%0d expected 10/5", access_count_b, hit_count_b); end
   endtask

   task automatic test_reset_mid_run();
      mode = 2'd0; req_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (access_count !== 32'd2 || busy !== 1'b1 || write_en !== 1'b1) begin n_err++; $display("FAIL t5_pre: got cnt=%0d busy=%b wr=%b expected 2/1/1", access_count, busy, write_en); end
      reset = 1'b0;
      #1;
      n_cmp++; if ({write_en, read_en, busy, done} !== 4'b0000 || address !== 16'h0 || write_data !== 32'h0) begin n_err++; $display("FAIL t5_async_out: got %b %h %h expected 0", {write_en, read_en, busy, done}, address, write_data); end
      n_cmp++; if (access_count !== 32'h0 || hit_count !== 32'h0 || mismatch_cnt !== 16'h0) begin n_err++; $display("FAIL t5_async_cnt: got %h/%h/%h expected 0", access_count, hit_count, mismatch_cnt); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_capture(2'd0, 1'b0);
      n_cmp++; if (timed_out || n_cap !== 8 || cap_addr[0] !== 16'h0 || cap_addr[7] !== 16'hC) begin n_err++; $display("FAIL t5_rerun: got n=%0d a0=%h a7=%h expected 8/0/c", n_cap, cap_addr[0], cap_addr[7]); end
      n_cmp++; if (access_count !== 32'd8 || hit_count !== 32'd2) begin n_err++; $display("FAIL t5_counts: got %0d/%0d expected 8/2", access_count, hit_count); end
   endtask

   task automatic test_readback();
      logic [15:0] exp_mm;
`ifdef SEQ_READBACK_CHECK_EN
      exp_mm = 16'd1;
`else
      exp_mm = 16'd0;
`endif
      corrupt_en = 1'b1;
      run_capture(2'd0, 1'b0);
      corrupt_en = 1'b0;
      n_cmp++; if (timed_out || n_cap !== 8) begin n_err++; $display("FAIL t6_accepts: got %0d expected 8", n_cap); end
      n_cmp++; if (mismatch_cnt !== exp_mm) begin n_err++; $display("FAIL t6_mismatch: got %0d expected %0d", mismatch_cnt, exp_mm); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_strided_stall();
      test_lfsr();
      test_wrap();
      test_reset_mid_run();
      test_readback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
